// File: rtl/mitch_trunc_div8.sv
// Pipelined 8-bit signed approximate divider (Mitchell log-domain, truncated fraction).
// Three-stage valid/ready pipeline with a global stall; output is ones-complement Q8.8.
module mitch_trunc_div8 #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] q_o,
    output logic        dz_o,
    output logic        busy_o
);

    localparam int unsigned LW = 3 + FRAC_W;
    localparam int unsigned DW = 4 + FRAC_W;

    // Log word {k, f}: k is the leading-one position, f the truncated bits below it.
    function automatic logic [LW-1:0] log_enc(input logic [7:0] a);
        logic [2:0]        k;
        logic [FRAC_W-1:0] f;
        k = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (a[i]) k = 3'(i);
        end
        f = FRAC_W'({a, {FRAC_W{1'b0}}} >> k);
        return {k, f};
    endfunction

    logic advance;

    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic          sx_q, sx_d, sy_q, sy_d;
    logic [LW-1:0] lx_q, lx_d, ly_q, ly_d;
    logic          zx1_q, zx1_d, zy1_q, zy1_d;
    logic [DW-1:0] d_q, d_d;
    logic          s2_q, s2_d, zx2_q, zx2_d, zy2_q, zy2_d;
    logic [15:0]   q_q, q_d;
    logic          dz_q, dz_d;

    logic [7:0]        xa, ya;
    logic [3:0]        kd;
    logic [FRAC_W-1:0] fd;
    logic [15:0]       base, mag;
    logic [5:0]        sh, sh_neg;

    always_comb begin
        advance = ~v3_q | out_ready_i;

        xa = x_i ^ {8{x_i[7]}};
        ya = y_i ^ {8{y_i[7]}};

        kd     = d_q[DW-1 -: 4];
        fd     = d_q[FRAC_W-1:0];
        base   = 16'({1'b1, fd});
        sh     = {{2{kd[3]}}, kd} + 6'(8 - FRAC_W);
        sh_neg = 6'd0 - sh;
        mag    = sh[5] ? (base >> sh_neg) : (base << sh);

        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        lx_d  = lx_q;
        ly_d  = ly_q;
        zx1_d = zx1_q;
        zy1_d = zy1_q;
        d_d   = d_q;
        s2_d  = s2_q;
        zx2_d = zx2_q;
        zy2_d = zy2_q;
        q_d   = q_q;
        dz_d  = dz_q;

        if (advance) begin
            v1_d  = in_valid_i;
            v2_d  = v1_q;
            v3_d  = v2_q;

            sx_d  = x_i[7];
            sy_d  = y_i[7];
            lx_d  = log_enc(xa);
            ly_d  = log_enc(ya);
            zx1_d = (xa == 8'd0);
            zy1_d = (ya == 8'd0);

            d_d   = {1'b0, lx_q} - {1'b0, ly_q};
            s2_d  = sx_q ^ sy_q;
            zx2_d = zx1_q;
            zy2_d = zy1_q;

            // Zero divisor saturates and wins over a zero dividend.
            if (zy2_q) begin
                q_d  = s2_q ? 16'h8000 : 16'h7FFF;
                dz_d = 1'b1;
            end else if (zx2_q) begin
                q_d  = 16'h0000;
                dz_d = 1'b0;
            end else begin
                q_d  = mag ^ {16{s2_q}};
                dz_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
            lx_q  <= '0;
            ly_q  <= '0;
            zx1_q <= 1'b0;
            zy1_q <= 1'b0;
            d_q   <= '0;
            s2_q  <= 1'b0;
            zx2_q <= 1'b0;
            zy2_q <= 1'b0;
            q_q   <= 16'h0000;
            dz_q  <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            lx_q  <= lx_d;
            ly_q  <= ly_d;
            zx1_q <= zx1_d;
            zy1_q <= zy1_d;
            d_q   <= d_d;
            s2_q  <= s2_d;
            zx2_q <= zx2_d;
            zy2_q <= zy2_d;
            q_q   <= q_d;
            dz_q  <= dz_d;
        end
    end

    assign in_ready_o  = advance;
    assign out_valid_o = v3_q;
    assign q_o         = q_q;
    assign dz_o        = dz_q;
    assign busy_o      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_mitch_trunc_div8.sv
// Self-checking bench for mitch_trunc_div8: directed table, random stream against an
// arithmetic reference model, backpressure and asynchronous reset sequences.
module tb_mitch_trunc_div8;

    localparam int F = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  x_i;
    logic [7:0]  y_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] q_o;
    logic        dz_o;
    logic        busy_o;

    mitch_trunc_div8 #(.FRAC_W(F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .q_o         (q_o),
        .dz_o        (dz_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int npop = 0;

    logic [16:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [15:0] prev_q;
    logic        prev_dz;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] q;
        logic        dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Log of the ones-complement magnitude, from the definition: k = floor(log2 a),
    // f = truncated fraction of a / 2^k scaled by 2^F.
    function automatic int log_of(input int a);
        int k;
        int f;
        k = 0;
        while ((2 ** (k + 1)) <= a) k++;
        f = ((a * (2 ** F)) / (2 ** k)) - (2 ** F);
        return k * (2 ** F) + f;
    endfunction

    function automatic int mag_of(input logic [7:0] v);
        int sv;
        sv = int'($signed(v));
        return (sv < 0) ? (-sv - 1) : sv;
    endfunction

    function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y);
        int ax, ay, dd, kd, fd, sh, m;
        bit s;
        logic [15:0] mq;
        ax = mag_of(x);
        ay = mag_of(y);
        s  = x[7] ^ y[7];
        if (ay == 0) return {1'b1, (s ? 16'h8000 : 16'h7FFF)};
        if (ax == 0) return {1'b0, 16'h0000};
        dd = log_of(ax) - log_of(ay);
        kd = dd >>> F;
        fd = dd - kd * (2 ** F);
        sh = kd + 8 - F;
        m  = (sh >= 0) ? ((2 ** F + fd) * (2 ** sh)) : ((2 ** F + fd) / (2 ** (-sh)));
        mq = 16'(m);
        return {1'b0, (s ? ~mq : mq)};
    endfunction

    // One cycle: drive at negedge, then account for the handshakes of the coming posedge.
    task automatic step(input bit iv, input logic [7:0] x, input logic [7:0] y,
                        input bit ordy, output bit acc);
        logic [16:0] e;
        @(negedge clk);
        in_valid_i  = iv;
        x_i         = x;
        y_i         = y;
        out_ready_i = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid_o), 32'd1);
            chk("stall_q", 32'(q_o), 32'(prev_q));
            chk("stall_dz", 32'(dz_o), 32'(prev_dz));
        end
        if (out_valid_o && out_ready_i) begin
            npop++;
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_q", 32'(q_o), 32'(e[15:0]));
                chk("stream_dz", 32'(dz_o), 32'(e[16]));
            end
        end
        acc = iv && in_ready_o;
        if (acc) exp_q.push_back(model(x, y));
        prev_stall = out_valid_o && !out_ready_i;
        prev_q     = q_o;
        prev_dz    = dz_o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[7];
        logic [7:0]  bpx[5];
        logic [7:0]  bpy[5];
        int          bi;
        bit          acc;

        tbl[0] = '{x: 8'd100, y: 8'd5,   q: 16'h1500, dz: 1'b0};
        tbl[1] = '{x: 8'h9C,  y: 8'd5,   q: 16'hEBFF, dz: 1'b0};
        tbl[2] = '{x: 8'd1,   y: 8'd100, q: 16'h0002, dz: 1'b0};
        tbl[3] = '{x: 8'd7,   y: 8'd0,   q: 16'h7FFF, dz: 1'b1};
        tbl[4] = '{x: 8'hF9,  y: 8'hFF,  q: 16'h7FFF, dz: 1'b1};
        tbl[5] = '{x: 8'd0,   y: 8'd9,   q: 16'h0000, dz: 1'b0};
        tbl[6] = '{x: 8'd0,   y: 8'd0,   q: 16'h7FFF, dz: 1'b1};

        bpx = '{8'd10, 8'hEC, 8'd33, 8'h81, 8'd64};
        bpy = '{8'd3,  8'd7,  8'hF0, 8'd2,  8'h00};

        rst_n = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        x_i = 8'd0;
        y_i = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_q", 32'(q_o), 32'd0);
        chk("rst_dz", 32'(dz_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table with exact 3-edge latency.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid_i  = 1'b1;
            x_i         = tbl[i].x;
            y_i         = tbl[i].y;
            out_ready_i = 1'b1;
            #1;
            chk("tbl_in_ready", 32'(in_ready_o), 32'd1);
            @(negedge clk);
            in_valid_i = 1'b0;
            chk("tbl_lat1", 32'(out_valid_o), 32'd0);
            @(negedge clk);
            chk("tbl_lat2", 32'(out_valid_o), 32'd0);
            @(negedge clk);
            chk("tbl_lat3", 32'(out_valid_o), 32'd1);
            chk("tbl_q", 32'(q_o), 32'(tbl[i].q));
            chk("tbl_dz", 32'(dz_o), 32'(tbl[i].dz));
        end
        @(negedge clk);

        // Random stream with random bubbles and backpressure.
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 3) != 0, acc);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, 8'd0, 8'd0, 1'b1, acc);
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        step(1'b0, 8'd0, 8'd0, 1'b1, acc);

        // Backpressure: only three pairs fit while the consumer is stalled.
        bi = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bpx[bi], bpy[bi], 1'b0, acc);
            if (acc) bi++;
        end
        chk("bp_accepted", 32'(bi), 32'd3);
        chk("bp_in_ready", 32'(in_ready_o), 32'd0);
        npop = 0;
        for (int c = 0; c < 5; c++) begin
            step(bi < 5, bpx[bi % 5], bpy[bi % 5], 1'b1, acc);
            if (acc) bi++;
        end
        chk("bp_back_to_back", 32'(npop), 32'd5);
        chk("bp_all_accepted", 32'(bi), 32'd5);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with three items in flight.
        for (int c = 0; c < 3; c++) step(1'b1, 8'($urandom), 8'($urandom), 1'b1, acc);
        @(negedge clk);
        in_valid_i = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid_o), 32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_q", 32'(q_o), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 8'd0, 8'd0, 1'b1, acc);
            chk("post_rst_no_out", 32'(out_valid_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mitch_trunc_div8.md
Name:
mitch_trunc_div8

Overview:
- Pipelined 8-bit signed approximate divider using Mitchell's log-domain method: q ≈ x / y.
- Inverse counterpart of the team's truncated Mitchell multiplier. The multiplier adds logarithms; this block subtracts them.
- Uses the same ones-complement magnitude and sign convention and the same truncated-fraction LOD/normalise front end.
- Three-stage valid/ready pipeline that sits between a producer and consumer stream. Output is a signed Q8.8 quotient plus a divide-by-zero flag.

Parameters:
FRAC_W, 4, mantissa bits kept after normalisation (legal 1..7); log word L is 3+FRAC_W bits.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid_i, in, 1, dividend/divisor pair valid.
- in_ready_o, out, 1, block accepts the pair this cycle.
- x_i, in, 8, dividend (signed).
- y_i, in, 8, divisor (signed).
- out_valid_o, out, 1, result valid.
- out_ready_i, in, 1, consumer accepts the result.
- q_o, out, 16, quotient, ones-complement signed Q8.8.
- dz_o, out, 1, divisor magnitude was zero.
- busy_o, out, 1, any pipeline stage holds valid data.

Behaviour:
Reset (async assert, sync-safe deassert):
- All stage valid bits = 0; out_valid_o = 0, q_o = 0, dz_o = 0, busy_o = 0.
- Reset mid-operation discards all in-flight data; nothing is emitted after release.

Handshake and pipeline control:
- advance = ~out_valid_o | out_ready_i. Global stall: all three stage registers load only on advance.
- in_ready_o = advance. An input transfer occurs when in_valid_i & in_ready_o.
- Latency is 3 cycles from accepted input to out_valid_o when not stalled.
- Bubbles are not collapsed. Throughput is 1 per cycle.
- While out_valid_o & ~out_ready_i, q_o and dz_o hold stable.
- Data registers may update on any advance. The valid bits carry the meaning.

S1 (operand encode, registered):
- sx = x[7], sy = y[7].
- xa = x ^ {8{sx}}, ya = y ^ {8{sy}}. Range 0..127.
- kx = position of the leading one in xa (0..6).
- fx = bits [6:7-FRAC_W] of (xa << (7-kx)), i.e. truncation, no rounding.
- Lx = kx*2^FRAC_W + fx. Ly is computed the same way from ya.
- zx = (xa == 0), zy = (ya == 0).

S2 (log subtract, registered):
- D = Lx - Ly, signed, 4+FRAC_W bits.
- Also registered: s = sx ^ sy, zx, zy.

S3 (antilog + sign, registered to outputs):
- kD = D >>> FRAC_W (floor). fD = D[FRAC_W-1:0].
- mag = (2^FRAC_W + fD) shifted by (kD + 8 - FRAC_W): left if non-negative, else logical right (truncate).
- Maximum mag is 32640, so bit 15 is never set.
- Normal case: q = mag ^ {16{s}}, dz = 0.
- zy = 1: q = s ? 16'h8000 : 16'h7FFF, dz = 1. This takes precedence over zx.
- zx = 1 and zy = 0: q = 16'h0000, dz = 0. The sign is not applied.
- busy_o = OR of the three stage valid bits.

Test Plan:
1. x=100, y=5 (FRAC_W=4): Lx=105, Ly=36, D=69 -> q_o=0x1500, dz_o=0, out_valid_o exactly 3 cycles after accept.
2. x=-100 (0x9C), y=5: xa=99, Lx=104, D=68 -> q_o=~0x1400=0xEBFF.
3. x=1, y=100: D=-105, kD=-7, fD=7 -> mag=23>>3 -> q_o=0x0002.
4. Zero cases:
   - x=7, y=0 -> q_o=0x7FFF, dz_o=1.
   - x=-7, y=-1 -> q_o=0x7FFF, dz_o=1.
   - x=0, y=9 -> q_o=0x0000, dz_o=0.
   - x=0, y=0 -> q_o=0x7FFF, dz_o=1.
5. Backpressure:
   - Stream 5 pairs with out_ready_i=0 -> after the 3rd accept, in_ready_o=0 and q_o stays stable.
   - Raise out_ready_i -> results emerge in order, one per cycle, none lost or duplicated.
6. Reset mid-stream:
   - Drop rst_n with 3 items in flight -> out_valid_o=0 and busy_o=0 immediately (asynchronous).
   - After release, with no new input -> no output appears.
